// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the shared-register arbiter: FSM state
// encoding, grant-index width helper and write-counter width.
package shared_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int WR_CNT_W = 16;

  // A single requester still needs a 1-bit index to keep port widths legal.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask) scanning
// upward from ptr with wrap-around.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] cand;

  always_comb begin : scan
    int pos;
    pos   = 0;
    cand  = req & ~mask;
    valid = |cand;
    idx   = '0;
    // Walk the window backwards so the candidate closest to ptr wins last.
    for (int i = N - 1; i >= 0; i--) begin
      pos = (int'(ptr) + i) % N;
      if (cand[pos]) begin
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Single-owner write arbiter for one shared register: round-robin grant with a
// bounded hold per owner. Define ARB_FIXED_PRIO_EN to make requester 0 preempt.
//
// state | meaning
// IDLE  | no owner, arbitrating over all requests from rr_ptr
// OWN   | grant_id owns the register; writes commit while its req is high
module shared_reg_arbiter
  import shared_arb_pkg::*;
#(
  parameter int                N_REQ    = 4,
  parameter int                DATA_W   = 8,
  parameter int                HOLD_MAX = 4,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        grant,
  output logic [id_w(N_REQ)-1:0]  grant_id,
  output logic                    busy,
  output logic [DATA_W-1:0]       reg_q,
  output logic [WR_CNT_W-1:0]     wr_cnt
);

  localparam int              ID_W      = id_w(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_MAX - 1);

  arb_state_e       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [7:0]       hold_cnt;

  logic             wr_en;
  logic             last_write;
  logic             prio_win;
  logic             release_own;
  logic             pick_valid;
  logic             win_valid;
  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  scan_ptr;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  win_idx;
  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] scan_mask;

  assign owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign wr_en      = (state == OWN) && |(grant & req);
  assign last_write = wr_en && (hold_cnt == HOLD_LAST);
  assign next_ptr   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

`ifdef ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks, unless it is already the owner.
  assign prio_win = req[0] && !((state == OWN) && (grant_id == '0));
`else
  assign prio_win = 1'b0;
`endif

  assign release_own = (state == OWN) && (!wr_en || last_write || prio_win);

  // On release the outgoing owner is masked so it can only return via IDLE.
  assign scan_ptr  = (state == OWN) ? next_ptr : rr_ptr;
  assign scan_mask = (state == OWN) ? owner_mask : '0;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req),
    .mask  (scan_mask),
    .ptr   (scan_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_valid = prio_win | pick_valid;
  assign win_idx   = prio_win ? '0 : pick_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      reg_q    <= RST_VAL;
      wr_cnt   <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            grant_id <= win_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (wr_en) begin
            reg_q    <= wdata[grant_id*DATA_W +: DATA_W];
            wr_cnt   <= wr_cnt + 1'b1;
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (release_own) begin
            rr_ptr   <= next_ptr;
            hold_cnt <= '0;
            if (win_valid) begin
              grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
              grant_id <= win_idx;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (default build, round-robin only):
// directed scenarios with literal expectations plus a per-cycle reference model.
module tb_shared_reg_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  reg_q;
  logic [15:0] wr_cnt;

  int total;
  int bad;

  shared_reg_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .HOLD_MAX (HOLD),
    .RST_VAL  (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .reg_q    (reg_q),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns, where the scan starts, how many writes so far.
  int          m_owner;
  int          m_ptr;
  int          m_hold;
  logic [7:0]  m_reg;
  logic [15:0] m_cnt;
  bit          started;

  function automatic int pick(input logic [3:0] r, input int excl, input int start);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int  g;
    bit  rel;
    started = 1'b1;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_reg   = 8'h00;
      m_cnt   = 16'd0;
    end else if (m_owner < 0) begin
      m_owner = pick(req, -1, m_ptr);
      m_hold  = 0;
    end else begin
      g   = m_owner;
      rel = 1'b0;
      if (req[g]) begin
        m_reg  = wdata[g*DW +: DW];
        m_cnt  = m_cnt + 16'd1;
        m_hold = m_hold + 1;
        if (m_hold == HOLD) rel = 1'b1;
      end else begin
        rel = 1'b1;
      end
      if (rel) begin
        m_ptr   = (g + 1) % N;
        m_owner = pick(req, g, m_ptr);
        m_hold  = 0;
      end
    end
  end

  function automatic logic [3:0] exp_grant(input int owner);
    logic [3:0] one;
    one = 4'b0001;
    return (owner >= 0) ? (one << owner) : 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      total++;
      if (grant !== exp_grant(m_owner) || busy !== (m_owner >= 0) || reg_q !== m_reg ||
          wr_cnt !== m_cnt || (m_owner >= 0 && grant_id !== 2'(m_owner))) begin
        bad++;
        $display("FAIL model t=%0t grant=%b/%b busy=%b/%b id=%0d/%0d reg_q=%h/%h wr_cnt=%0d/%0d",
                 $time, grant, exp_grant(m_owner), busy, (m_owner >= 0), grant_id, m_owner,
                 reg_q, m_reg, wr_cnt, m_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    req     = 4'b1111;
    wdata   = 32'h4332_2110;
    total   = 0;
    bad     = 0;
    started = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_reg   = 8'h00;
    m_cnt   = 16'd0;

    // Reset dominates a full set of requests.
    step(2);
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst reg_q", 32'(reg_q), 32'h0);
    chk("rst wr_cnt", 32'(wr_cnt), 32'h0);

    // All requesters high: four writes each in strict rotation.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("rotation grant", 32'(grant), 32'(1) << (i / 4));
      if (i == 0) chk("grant edge wr_cnt", 32'(wr_cnt), 32'h0);
      if (i == 1) chk("first write reg_q", 32'(reg_q), 32'h10);
    end
    step(1);
    chk("rotation wr_cnt", 32'(wr_cnt), 32'd16);
    chk("rotation reg_q", 32'(reg_q), 32'h43);
    chk("rotation wrap grant", 32'(grant), 32'h1);

    // Lone requester 2 writes twice, then rr_ptr must sit at 3.
    rst = 1'b1; req = 4'b0000; step(1);
    rst = 1'b0; req = 4'b0100; step(1);
    chk("req2 grant", 32'(grant), 32'h4);
    step(2);
    chk("req2 wr_cnt", 32'(wr_cnt), 32'd2);
    chk("req2 reg_q", 32'(reg_q), 32'h32);
    req = 4'b0000; step(1);
    chk("req2 release grant", 32'(grant), 32'h0);
    chk("req2 release busy", 32'(busy), 32'h0);
    chk("req2 release wr_cnt", 32'(wr_cnt), 32'd2);
    req = 4'b1010; step(1);
    chk("ptr3 grant", 32'(grant), 32'h8);
    chk("ptr3 grant_id", 32'(grant_id), 32'd3);

    // Owner 1 drops while requester 0 waits: direct hand-over, no write.
    rst = 1'b1; req = 4'b0000; step(1);
    rst = 1'b0; req = 4'b0001; step(2);
    req = 4'b0000; step(1);
    chk("drop0 busy", 32'(busy), 32'h0);
    req = 4'b0010; step(1);
    chk("owner1 grant", 32'(grant), 32'h2);
    step(1);
    chk("owner1 reg_q", 32'(reg_q), 32'h21);
    req = 4'b0001; step(1);
    chk("handover grant", 32'(grant), 32'h1);
    chk("handover reg_q", 32'(reg_q), 32'h21);
    chk("handover wr_cnt", 32'(wr_cnt), 32'd2);

    // Reset while owner 0 has a write pending.
    rst = 1'b1; step(1);
    chk("midrst reg_q", 32'(reg_q), 32'h0);
    chk("midrst wr_cnt", 32'(wr_cnt), 32'h0);
    chk("midrst grant", 32'(grant), 32'h0);

    // Requester 0 rising does not cut owner 2 short in round-robin mode.
    rst = 1'b1; req = 4'b0000; step(1);
    rst = 1'b0; req = 4'b0100; step(1);
    chk("hold grant", 32'(grant), 32'h4);
    step(1);
    req = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("hold keep grant", 32'(grant), 32'h4);
    end
    step(1);
    chk("hold release grant", 32'(grant), 32'h1);
    chk("hold wr_cnt", 32'(wr_cnt), 32'd4);
    chk("hold reg_q", 32'(reg_q), 32'h32);

    // Random traffic, checked cycle by cycle against the model.
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom);
      wdata = $urandom;
      rst   = ($urandom_range(0, 59) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Arbitrates write access to one shared register among N_REQ requesters, so the register has exactly one driver instead of several competing always/assign drivers.
- Grant is round-robin with a bounded hold time per owner, sequenced by a two-state FSM.
- Sits between requesting logic and the single storage register it owns, and exports the register value.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 8, shared register width
- HOLD_MAX, 4, maximum consecutive write cycles per grant (1..255)
- RST_VAL, 0, reset value of the shared register

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  N_REQ  per-requester write request, level
- wdata  in  N_REQ*DATA_W  packed write data; slice i = wdata[i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot registered grant
- grant_id  out  $clog2(N_REQ)  index of current owner, valid when busy=1
- busy  out  1  1 while FSM is in OWN
- reg_q  out  DATA_W  shared register value
- wr_cnt  out  16  total committed writes, wraps modulo 2^16

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: grant=0, grant_id=0, busy=0, reg_q=RST_VAL, wr_cnt=0, rr_ptr=0, hold_cnt=0, state=IDLE. rst dominates all other inputs on the same edge.
- FSM states: IDLE, OWN.
  - IDLE: if any req is high, pick the first set req scanning from rr_ptr upward with wrap. Next edge: grant one-hot, grant_id=pick, hold_cnt=0, state=OWN. If no req is high, stay in IDLE.
- Write (OWN):
  - Each cycle where grant[g]=1 and req[g]=1, the edge commits reg_q<=wdata slice g, increments wr_cnt and increments hold_cnt.
  - Latency: req rising at edge k gives grant at edge k+1; the first write commits at edge k+2.
- Release: leave ownership when either
  - req[g]=0 while granted (no write that cycle), or
  - the committed write makes hold_cnt reach HOLD_MAX.
- On release:
  - rr_ptr=(g+1) mod N_REQ.
  - Re-arbitrate in the same cycle over req excluding g, scanning from the new rr_ptr.
  - If a winner exists, the next edge grants it directly (back-to-back, no IDLE bubble). Otherwise grant=0, busy=0, state=IDLE.
  - g may be re-granted only through a later IDLE arbitration.
- Fairness bounds:
  - With all requesters held high, each gets exactly HOLD_MAX writes in rotation 0,1,2,3,0...
  - Worst-case wait is (N_REQ-1)*(HOLD_MAX+1) cycles.
- Invariants:
  - grant is one-hot or zero.
  - reg_q changes only on a committed write or rst.
  - Non-granted wdata is ignored.
- The FSM and next-state logic must be full-case with a default branch. No latches; combinational blocks assign all outputs.
- rst asserted mid-ownership: the write that cycle is discarded and all state returns to reset values.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 is high priority.
  - If req[0]=1 while another owner holds, that owner is released after its current cycle's write, and requester 0 is granted on the next edge.
  - Requester 0 itself is still limited by HOLD_MAX; afterwards round-robin resumes from rr_ptr=1.
- Undefined: pure round-robin, all requesters equal.

Decomposition:
- Package shared_arb_pkg holds:
  - state typedef (IDLE=1'b0, OWN=1'b1);
  - localparam functions for the id width;
  - the wr_cnt width constant (16).
- Sub-module rr_pick: combinational, inputs req, mask, ptr; outputs valid, idx. Instantiated once; reused for both IDLE and release arbitration.

Test Plan:
- Reset with req=4'b1111: after rst, grant=0, reg_q=0, wr_cnt=0; grant=0001 at edge 1 after rst release, first write at edge 2.
- All req high, HOLD_MAX=4, wdata slices 0x10,0x21,0x32,0x43: grant sequence 0001x4, 0010x4, 0100x4, 1000x4 with no gaps; wr_cnt=16 after 16 write cycles; reg_q=0x43 at the end.
- Single req[2] pulsed for 2 cycles: exactly 2 writes, then grant=0, busy=0, rr_ptr=3; a subsequent req[1] & req[3] is granted to 3 first.
- Owner 1 drops req while req[0] is high: the next edge grants 0 directly; no write occurs in the drop cycle and reg_q is unchanged.
- rst pulsed mid-OWN with a pending write: reg_q=RST_VAL, wr_cnt=0, grant=0 on the following cycle.
- ARB_FIXED_PRIO_EN defined: owner 2 writing, req[0] rises; owner 2 commits that cycle and grant=0001 on the next edge. Without the macro, owner 2 keeps the grant until HOLD_MAX.
